datapath_xant_deint: RTL and testbench
======================================

// Module: datapath_xant_deint
// PURPOSE
//  Downstream consumer of the datapath delay stage. Takes the delayed 4-antenna TDM stream
//  (32b IQ per cycle, frame/antenna headers) and de-interleaves each 4-sample group into one
//  128b word. A lock FSM qualifies antenna alignment; a frame-length checker flags bad headers.
// PARAMETERS
//  FRAM_LEN    2457600  clock cycles per frame (10 ms @ 245.76 MHz)
//  LOCK_CNT    4        consecutive good groups needed to enter LOCKED
//  UNLOCK_CNT  3        consecutive bad groups needed to drop back to HUNT
// PORTS
//  clk         in   1    datapath clock (single clock domain)
//  rst         in   1    asynchronous reset, active-low
//  i_fram_hd   in   1    1-cycle pulse, cycle before antenna 0 of the first group of a frame
//  i_xant_hd   in   1    1-cycle pulse on the antenna-3 (last) sample of each group
//  i_data      in   32   TDM sample, antenna order 0,1,2,3
//  i_stat_clr  in   1    clears statistics counters (used only with the stat feature)
//  o_vld       out  1    1-cycle strobe, o_data holds a complete group
//  o_fram_hd   out  1    coincident with the first o_vld of a frame
//  o_data      out  128  {ant3,ant2,ant1,ant0}
//  o_lock      out  1    FSM in LOCKED
//  o_fram_err  out  1    1-cycle pulse on frame-length violation
//  o_grp_cnt   out  32   groups output (stat feature)
//  o_err_cnt   out  16   frame+alignment errors, saturating (stat feature)
// BEHAVIOUR
//  - Reset: all outputs 0, slot=0, FSM=HUNT, frame counter 0, frame_seen=0.
//  - Slot counter 0..3 wraps every cycle; i_fram_hd forces slot=0 next cycle in any state.
//  - Sample at slot k written to lane k; at slot 3 the lanes are registered to o_data:
//    latency = 1 cycle after the antenna-3 input cycle. o_vld only when o_lock=1.
//  - Group check at slot 3: good = i_xant_hd=1; bad = i_xant_hd=0, or i_xant_hd=1 at slot!=3
//    (a bad flag at slot!=3 is latched and applied at the next slot-3 evaluation).
//  - FSM HUNT: ignores i_xant_hd until i_fram_hd -> CHECK (good cnt=0).
//    CHECK: good -> cnt+1, cnt reaches LOCK_CNT -> LOCKED; bad -> HUNT.
//    LOCKED: flywheel, slot never realigned by i_xant_hd; bad -> miss+1, good -> miss=0;
//    miss reaches UNLOCK_CNT -> HUNT (o_lock falls same edge, no further o_vld).
//  - o_fram_hd: set on the o_vld of the first group after i_fram_hd; if not LOCKED then, dropped.
//  - Frame counter 0..FRAM_LEN-1, width $clog2(FRAM_LEN); i_fram_hd resets it to 0.
//    First i_fram_hd after reset sets frame_seen, not checked. Afterwards:
//    i_fram_hd with cnt!=FRAM_LEN-1 -> o_fram_err (early);
//    cnt==FRAM_LEN-1 and no i_fram_hd -> o_fram_err (missing), counter wraps to 0.
//  - Simultaneous i_fram_hd and i_xant_hd: xant check evaluated against the current slot
//    first (closes previous frame), then slot realigned.
//  - Reset asserted mid-frame: immediate return to reset state; o_vld/o_lock drop async.
// CONFIGURATION
//  `DATAPATH_XANT_DEINT_STAT_EN defined: o_grp_cnt increments per o_vld (wraps 2^32);
//    o_err_cnt increments per o_fram_err and per bad group in LOCKED, saturates 16'hFFFF;
//    both clear on i_stat_clr (clear wins over same-cycle increment).
//  Not defined: counters not built, o_grp_cnt/o_err_cnt tied to 0, i_stat_clr unused.
// STRUCTURE
//  Package datapath_xant_pkg: NUM_ANT=4, IQ_W=32, state enum {HUNT,CHECK,LOCKED}, slot type.
//  Sub-module datapath_fram_len_chk (FRAM_LEN param): frame counter, frame_seen, o_fram_err.
//  FSM, lane registers and stat counters stay in the top.
// TESTING (bench uses FRAM_LEN=64)
//  1 Clean stream: fram_hd every 64 cycles, xant_hd every 4th, data=cycle idx -> lock after
//    1+4 groups, o_data={n+3,n+2,n+1,n} 1 cycle after antenna 3, o_fram_err never.
//  2 Early fram_hd at cnt 40 -> o_fram_err 1 cycle, slot realigned, lock held if xant good.
//  3 Omit one fram_hd -> o_fram_err when cnt==63, counter wraps, no o_fram_hd that frame.
//  4 Shift xant_hd by 1 cycle while LOCKED -> 3 bad groups -> o_lock=0, o_vld stops;
//    next fram_hd + 4 good groups -> relock.
//  5 Assert rst mid-frame while LOCKED -> o_lock/o_vld 0 immediately, HUNT, stats cleared.
//  6 STAT_EN: 10 locked groups -> o_grp_cnt=10; i_stat_clr with o_vld -> 0; force err 70000x
//    -> o_err_cnt=16'hFFFF.

Source files
------------

// File: rtl/datapath_xant_pkg.sv
// Shared types for the 4-antenna TDM de-interleaver: antenna count, sample width, slot and lock-state types.
package datapath_xant_pkg;

  localparam int NUM_ANT = 4;
  localparam int IQ_W    = 32;
  localparam int SLOT_W  = $clog2(NUM_ANT);

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_ANT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } xant_state_e;

endpackage

// File: rtl/datapath_fram_len_chk.sv
// Frame-length checker: counts cycles between frame headers and pulses o_fram_err on early or missing header.
// Latency: o_fram_err one cycle after the offending cycle. No backpressure.
module datapath_fram_len_chk #(
  parameter int FRAM_LEN = 2457600
) (
  input  logic clk,
  input  logic rst,
  input  logic i_fram_hd,
  output logic o_fram_err
);

  localparam int                CNT_W    = $clog2(FRAM_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAM_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             err_q, err_d;

  // The first header after reset only arms the checker; it has no reference to be late or early against.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    seen_d = seen_q;
    err_d  = 1'b0;
    if (i_fram_hd) begin
      cnt_d  = '0;
      seen_d = 1'b1;
      err_d  = seen_q && (cnt_q != CNT_LAST);
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      err_d = seen_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      err_q  <= err_d;
    end
  end

  assign o_fram_err = err_q;

endmodule

// File: rtl/datapath_xant_deint.sv
// De-interleaves 4-antenna TDM samples into 128b groups behind a HUNT/CHECK/LOCKED alignment FSM.
// Latency: o_data/o_vld one cycle after the antenna-3 sample. No backpressure: o_vld is a strobe.
// Optional statistics counters are built with DATAPATH_XANT_DEINT_STAT_EN.
module datapath_xant_deint
  import datapath_xant_pkg::*;
#(
  parameter int FRAM_LEN   = 2457600,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_fram_hd,
  input  logic                    i_xant_hd,
  input  logic [IQ_W-1:0]         i_data,
  input  logic                    i_stat_clr,
  output logic                    o_vld,
  output logic                    o_fram_hd,
  output logic [NUM_ANT*IQ_W-1:0] o_data,
  output logic                    o_lock,
  output logic                    o_fram_err,
  output logic [31:0]             o_grp_cnt,
  output logic [15:0]             o_err_cnt
);

  localparam int GC_W = $clog2(LOCK_CNT + 1);
  localparam int MC_W = $clog2(UNLOCK_CNT + 1);

  slot_t                         slot_q, slot_d;
  xant_state_e                   state_q, state_d;
  logic [GC_W-1:0]               good_q, good_d;
  logic [MC_W-1:0]               miss_q, miss_d;
  logic                          bad_q, bad_d;
  logic                          pend_q, pend_d;
  logic [NUM_ANT-2:0][IQ_W-1:0]  lane_q;
  logic [NUM_ANT*IQ_W-1:0]       data_q, data_d;
  logic                          vld_q, vld_d;
  logic                          fhd_q, fhd_d;
  logic                          grp_end, grp_good;

  assign grp_end  = (slot_q == LAST_SLOT);
  assign grp_good = i_xant_hd && !bad_q;

  always_comb begin
    slot_d  = grp_end ? '0 : slot_q + slot_t'(1);
    state_d = state_q;
    good_d  = good_q;
    miss_d  = miss_q;
    bad_d   = bad_q;
    pend_d  = pend_q;
    data_d  = data_q;

    // The group check uses the pre-realignment slot, so a header coinciding with xant closes the old group.
    if (i_fram_hd) slot_d = '0;

    if (state_q == HUNT || grp_end) bad_d = 1'b0;
    else if (i_xant_hd)             bad_d = 1'b1;

    if (i_fram_hd)    pend_d = 1'b1;
    else if (grp_end) pend_d = 1'b0;

    case (state_q)
      HUNT: begin
        if (i_fram_hd) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (grp_end) begin
          if (!grp_good) begin
            state_d = HUNT;
          end else if (good_q == GC_W'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            miss_d  = '0;
          end else begin
            good_d = good_q + GC_W'(1);
          end
        end
      end
      LOCKED: begin
        if (grp_end) begin
          if (grp_good)                             miss_d  = '0;
          else if (miss_q == MC_W'(UNLOCK_CNT - 1)) state_d = HUNT;
          else                                      miss_d  = miss_q + MC_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase

    if (grp_end) data_d = {i_data, lane_q};
    vld_d = grp_end && (state_d == LOCKED);
    fhd_d = vld_d && pend_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q  <= '0;
      state_q <= HUNT;
      good_q  <= '0;
      miss_q  <= '0;
      bad_q   <= 1'b0;
      pend_q  <= 1'b0;
      lane_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      fhd_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      state_q <= state_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      bad_q   <= bad_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      fhd_q   <= fhd_d;
      if (!grp_end) lane_q[slot_q] <= i_data;
    end
  end

  assign o_vld     = vld_q;
  assign o_fram_hd = fhd_q;
  assign o_data    = data_q;
  assign o_lock    = (state_q == LOCKED);

  datapath_fram_len_chk #(.FRAM_LEN(FRAM_LEN)) u_fram_len_chk (
    .clk        (clk),
    .rst        (rst),
    .i_fram_hd  (i_fram_hd),
    .o_fram_err (o_fram_err)
  );

`ifdef DATAPATH_XANT_DEINT_STAT_EN
  logic [31:0] grp_cnt_q;
  logic [15:0] err_cnt_q;
  logic        bad_locked;
  logic [16:0] err_sum;

  assign bad_locked = grp_end && (state_q == LOCKED) && !grp_good;
  assign err_sum    = {1'b0, err_cnt_q} + {16'd0, o_fram_err} + {16'd0, bad_locked};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grp_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (i_stat_clr) begin
      grp_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (vld_d) grp_cnt_q <= grp_cnt_q + 32'd1;
      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign o_grp_cnt = grp_cnt_q;
  assign o_err_cnt = err_cnt_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = i_stat_clr;
  assign o_grp_cnt       = '0;
  assign o_err_cnt       = '0;
`endif

endmodule

// File: tb/tb_datapath_xant_deint.sv
// Bench for datapath_xant_deint with FRAM_LEN=64: group table plus scoreboard, then reset and statistics sequences.
module tb_datapath_xant_deint;

  localparam int FL = 64;
  localparam int NO = 9;
`ifdef DATAPATH_XANT_DEINT_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_fram_hd = 1'b0;
  logic         i_xant_hd = 1'b0;
  logic         i_stat_clr = 1'b0;
  logic [31:0]  i_data = '0;
  logic         o_vld, o_fram_hd, o_lock, o_fram_err;
  logic [127:0] o_data;
  logic [31:0]  o_grp_cnt;
  logic [15:0]  o_err_cnt;

  always #5 clk = ~clk;

  datapath_xant_deint #(.FRAM_LEN(FL), .LOCK_CNT(4), .UNLOCK_CNT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_fram_hd  (i_fram_hd),
    .i_xant_hd  (i_xant_hd),
    .i_data     (i_data),
    .i_stat_clr (i_stat_clr),
    .o_vld      (o_vld),
    .o_fram_hd  (o_fram_hd),
    .o_data     (o_data),
    .o_lock     (o_lock),
    .o_fram_err (o_fram_err),
    .o_grp_cnt  (o_grp_cnt),
    .o_err_cnt  (o_err_cnt)
  );

  // One group of the input stream: cycle count, xant/fram positions (NO = absent), expected results.
  typedef struct {
    int len;
    int xpos;
    int fpos;
    bit e_vld;
    bit e_fhd;
    bit e_lock;
    int e_err;
    bit clr;
  } grp_t;

  typedef struct {
    logic [127:0] dat;
    logic         fhd;
  } exp_t;

  grp_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_idx = 0;
  int   n_vld_exp = 0;
  int   err_seen = 0;

  function automatic grp_t mk(int len, int xpos, int fpos, bit v, bit f, bit l, int e, bit clr = 1'b0);
    grp_t g;
    g.len = len; g.xpos = xpos; g.fpos = fpos;
    g.e_vld = v; g.e_fhd = f; g.e_lock = l; g.e_err = e; g.clr = clr;
    return g;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_idx);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (o_fram_err) err_seen++;
    if (o_vld) begin
      chk("vld_expected", 128'(sb.size() > 0), 128'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("o_data", o_data, e.dat);
        chk("o_fram_hd", 128'(o_fram_hd), 128'(e.fhd));
      end
    end else begin
      chk("o_fram_hd_idle", 128'(o_fram_hd), 128'd0);
    end
  endtask

  task automatic run_grp(grp_t g);
    logic [31:0] d0;
    exp_t        e;
    d0 = 32'(cyc_idx);
    err_seen = 0;
    for (int b = 0; b < g.len; b++) begin
      i_data     = 32'(cyc_idx);
      i_xant_hd  = (b == g.xpos);
      i_fram_hd  = (b == g.fpos);
      i_stat_clr = g.clr && (b == 3);
      if (b == 3 && g.e_vld) begin
        e.dat = {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
        e.fhd = g.e_fhd;
        sb.push_back(e);
        n_vld_exp++;
      end
      tick();
      cyc_idx++;
    end
    i_xant_hd  = 1'b0;
    i_fram_hd  = 1'b0;
    i_stat_clr = 1'b0;
    chk("o_lock", 128'(o_lock), 128'(g.e_lock));
    chk("o_fram_err_pulses", 128'(err_seen), 128'(g.e_err));
  endtask

  initial begin
    // Clean lock-in: one HUNT group, header, then 4 good groups in CHECK.
    tbl.push_back(mk(4, 3, NO, 0, 0, 0, 0));
    tbl.push_back(mk(4, 3, 3, 0, 0, 0, 0));
    for (int r = 0; r < 16; r++) tbl.push_back(mk(4, 3, (r == 15) ? 3 : NO, r >= 3, 0, r >= 3, 0));
    // Early header at frame count 40 realigns the slot mid-group.
    for (int r = 0; r < 10; r++) tbl.push_back(mk(4, 3, NO, 1, r == 0, 1, 0));
    tbl.push_back(mk(1, NO, 0, 0, 0, 1, 1));
    for (int r = 0; r < 16; r++) tbl.push_back(mk(4, 3, (r == 15) ? 3 : NO, 1, r == 0, 1, 0));
    // Missing header: error at count 63, and the next frame carries no o_fram_hd.
    for (int r = 0; r < 16; r++) tbl.push_back(mk(4, 3, NO, 1, r == 0, 1, (r == 15) ? 1 : 0));
    for (int r = 0; r < 16; r++) tbl.push_back(mk(4, 3, (r == 15) ? 3 : NO, 1, 0, 1, 0));
    // xant slips one cycle late while locked: three bad groups drop the lock.
    for (int r = 0; r < 5; r++) tbl.push_back(mk(4, 3, NO, 1, r == 0, 1, 0));
    tbl.push_back(mk(4, NO, NO, 1, 0, 1, 0));
    tbl.push_back(mk(4, 0, NO, 1, 0, 1, 0));
    tbl.push_back(mk(4, 0, NO, 0, 0, 0, 0));
    for (int r = 8; r < 15; r++) tbl.push_back(mk(4, 0, NO, 0, 0, 0, 0));
    tbl.push_back(mk(4, 0, 3, 0, 0, 0, 0));
    for (int r = 0; r < 16; r++) tbl.push_back(mk(4, 3, (r == 15) ? 3 : NO, r >= 3, 0, r >= 3, 0));
    for (int r = 0; r < 6; r++) tbl.push_back(mk(4, 3, NO, 1, r == 0, 1, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_vld", 128'(o_vld), 128'd0);
    chk("rst_o_lock", 128'(o_lock), 128'd0);
    chk("rst_o_data", o_data, 128'd0);
    chk("rst_o_fram_err", 128'(o_fram_err), 128'd0);
    chk("rst_o_grp_cnt", 128'(o_grp_cnt), 128'd0);
    chk("rst_o_err_cnt", 128'(o_err_cnt), 128'd0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_grp(tbl[i]);

    chk("sb_drained", 128'(sb.size()), 128'd0);
    chk("grp_cnt_table", 128'(o_grp_cnt), STAT ? 128'(n_vld_exp) : 128'd0);
    chk("err_cnt_table", 128'(o_err_cnt), STAT ? 128'd5 : 128'd0);

    // Asynchronous reset right after a locked o_vld strobe.
    chk("vld_before_rst", 128'(o_vld), 128'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_o_vld", 128'(o_vld), 128'd0);
    chk("async_rst_o_lock", 128'(o_lock), 128'd0);
    chk("async_rst_o_data", o_data, 128'd0);
    chk("async_rst_grp_cnt", 128'(o_grp_cnt), 128'd0);
    chk("async_rst_err_cnt", 128'(o_err_cnt), 128'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Back in HUNT: good xant alone does not lock; the first header after reset is not checked.
    n_vld_exp = 0;
    run_grp(mk(4, 3, NO, 0, 0, 0, 0));
    run_grp(mk(4, 3, NO, 0, 0, 0, 0));
    run_grp(mk(4, 3, 3, 0, 0, 0, 0));
    for (int r = 0; r < 13; r++) run_grp(mk(4, 3, NO, r >= 3, 0, r >= 3, 0));
    chk("grp_cnt_ten", 128'(o_grp_cnt), STAT ? 128'd10 : 128'd0);

    run_grp(mk(4, 3, NO, 1, 0, 1, 0, 1'b1));
    chk("grp_cnt_clr_wins", 128'(o_grp_cnt), 128'd0);
    chk("err_cnt_after_clr", 128'(o_err_cnt), 128'd0);

    // A header every cycle is an early header every cycle: drives the error counter into saturation.
    for (int i = 0; i < 70000; i++) begin
      i_fram_hd = 1'b1;
      tick();
      cyc_idx++;
    end
    i_fram_hd = 1'b0;
    tick();
    tick();
    chk("err_cnt_saturated", 128'(o_err_cnt), STAT ? 128'h0000_FFFF : 128'd0);
    chk("sb_final", 128'(sb.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
